// File: rtl/mole_pkg.sv
// Shared constants for the whack-a-mole game: FSM encodings, LFSR seed/taps, tick period.
package mole_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 taps on a left-shifting register: bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [24:0] TICK_PERIOD = 25'd24999999;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR, steps each cycle while en is high; seeded non-zero so it never locks up.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/mole_controller.sv
// Raises one mole at a time on a pseudo-random hole, judges whacks as hit/miss, keeps a saturating score.
module mole_controller
  import mole_pkg::*;
#(
  parameter int NUM_HOLES = 4,
  parameter int UP_TICKS  = 3,
  parameter int SCORE_W   = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 play,
  input  logic                 tick,
  input  logic [NUM_HOLES-1:0] whack,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic                 hit,
  output logic                 miss
);

  localparam int HW = $clog2(NUM_HOLES);
  localparam logic [3:0] UP_INIT = 4'(UP_TICKS - 1);

  logic [1:0]           state;
  logic [3:0]           up_cnt;
  logic [HW-1:0]        prev_hole;
  logic [NUM_HOLES-1:0] whack_prev;
  logic [7:0]           lfsr;
  logic                 unused_lfsr;

  logic [HW-1:0]        cand;
  logic [HW-1:0]        hole;
  logic [NUM_HOLES-1:0] hole_onehot;
  logic [NUM_HOLES-1:0] whack_edge;
  logic                 good_whack;

  mole_lfsr u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .en     (play),
    .q      (lfsr)
  );

  assign unused_lfsr = ^lfsr;

  // Bumping a repeated candidate keeps consecutive moles on different holes.
  always_comb begin
    cand        = lfsr[HW-1:0];
    hole        = (cand == prev_hole) ? cand + HW'(1) : cand;
    hole_onehot = NUM_HOLES'(1) << hole;
    whack_edge  = whack & ~whack_prev;
    good_whack  = |(whack_edge & mole);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      whack_prev <= '0;
    end else begin
      whack_prev <= whack;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      mole      <= '0;
      score     <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      up_cnt    <= '0;
      prev_hole <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (!play) begin
        state <= ST_IDLE;
        mole  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            mole  <= '0;
            score <= '0;
            state <= ST_GAP;
          end
          ST_GAP: begin
            mole <= '0;
            if (tick) begin
              prev_hole <= hole;
              mole      <= hole_onehot;
              up_cnt    <= UP_INIT;
              state     <= ST_UP;
            end
          end
          ST_UP: begin
            // A correct whack wins over an expiring tick in the same cycle.
            if (good_whack) begin
              hit   <= 1'b1;
              mole  <= '0;
              state <= ST_GAP;
              if (score != {SCORE_W{1'b1}}) begin
                score <= score + SCORE_W'(1);
              end
            end else if (tick) begin
              if (up_cnt == 4'd0) begin
                miss  <= 1'b1;
                mole  <= '0;
                state <= ST_GAP;
              end else begin
                up_cnt <= up_cnt - 4'd1;
              end
            end
          end
          default: begin
            mole  <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_controller.sv
// Directed bench for mole_controller; a second instance with a 2-bit score shares the stimulus.
module tb_mole_controller;

  logic       clock;
  logic       resetn;
  logic       play;
  logic       tick;
  logic [3:0] whack;
  logic [3:0] mole;
  logic [7:0] score;
  logic       hit;
  logic       miss;
  logic [3:0] mole2;
  logic [1:0] score2;
  logic       hit2;
  logic       miss2;

  int n_checks = 0;
  int n_errors = 0;

  mole_controller #(.NUM_HOLES(4), .UP_TICKS(3), .SCORE_W(8)) dut (
    .clock (clock), .resetn (resetn), .play (play), .tick (tick), .whack (whack),
    .mole (mole), .score (score), .hit (hit), .miss (miss)
  );

  mole_controller #(.NUM_HOLES(4), .UP_TICKS(3), .SCORE_W(2)) dut_sat (
    .clock (clock), .resetn (resetn), .play (play), .tick (tick), .whack (whack),
    .mole (mole2), .score (score2), .hit (hit2), .miss (miss2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  logic [3:0] m;
  logic [3:0] prev_m;
  logic [3:0] seen;
  logic [3:0] idle_or;
  int         bad_onehot;
  int         repeats;

  initial begin
    resetn = 1'b0;
    play   = 1'b0;
    tick   = 1'b0;
    whack  = 4'h0;
    repeat (3) step();
    chk("rst_mole", 32'(mole), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_hit_miss", 32'({hit, miss}), 32'h0);
    resetn = 1'b1;

    // Ticks while idle must never raise a mole.
    idle_or = 4'h0;
    for (int i = 0; i < 100; i++) begin
      tick = (i % 10 == 3);
      step();
      idle_or |= mole;
    end
    tick = 1'b0;
    chk("idle_mole", 32'(idle_or), 32'h0);

    // Hit path
    play = 1'b1;
    step();
    chk("start_score", 32'(score), 32'h0);
    repeat (2) step();
    pulse_tick();
    m = mole;
    chk("rise_onehot", 32'($countones(m)), 32'd1);
    repeat (4) step();
    chk("pre_hit", 32'(hit), 32'h0);
    whack = m;
    step();
    whack = 4'h0;
    chk("hit_pulse", 32'(hit), 32'h1);
    chk("hit_score", 32'(score), 32'h1);
    chk("hit_mole", 32'(mole), 32'h0);
    step();
    chk("hit_one_cycle", 32'(hit), 32'h0);
    prev_m = m;

    // Miss path: three further ticks with no whack
    pulse_tick();
    m = mole;
    chk("rise2_onehot", 32'($countones(m)), 32'd1);
    chk("rise2_new_hole", 32'(m != prev_m), 32'h1);
    repeat (2) begin
      repeat (3) step();
      pulse_tick();
    end
    chk("up_after_2_ticks", 32'(mole), 32'(m));
    chk("no_early_miss", 32'(miss), 32'h0);
    repeat (3) step();
    pulse_tick();
    chk("miss_pulse", 32'(miss), 32'h1);
    chk("miss_mole", 32'(mole), 32'h0);
    chk("miss_score", 32'(score), 32'h1);
    step();
    chk("miss_one_cycle", 32'(miss), 32'h0);

    // Wrong hole is ignored, then the right one scores
    pulse_tick();
    m = mole;
    whack = {m[2:0], m[3]};
    step();
    whack = 4'h0;
    chk("wrong_no_hit", 32'(hit), 32'h0);
    chk("wrong_mole_up", 32'(mole), 32'(m));
    step();
    whack = m;
    step();
    whack = 4'h0;
    chk("right_hit", 32'(hit), 32'h1);
    chk("right_score", 32'(score), 32'h2);
    step();

    // Button held from before the rise never scores until re-pressed
    whack = 4'hF;
    step();
    pulse_tick();
    m = mole;
    repeat (3) step();
    chk("held_no_hit", 32'(hit), 32'h0);
    chk("held_mole_up", 32'(mole), 32'(m));
    whack = 4'h0;
    step();
    chk("release_no_hit", 32'(hit), 32'h0);
    whack = m;
    step();
    whack = 4'h0;
    chk("repress_hit", 32'(hit), 32'h1);
    chk("repress_score", 32'(score), 32'h3);
    step();

    // Correct whack coincident with the expiring tick counts as a hit
    pulse_tick();
    m = mole;
    repeat (2) begin
      step();
      pulse_tick();
    end
    chk("up_before_expire", 32'(mole), 32'(m));
    step();
    tick  = 1'b1;
    whack = m;
    step();
    tick  = 1'b0;
    whack = 4'h0;
    chk("simul_hit", 32'(hit), 32'h1);
    chk("simul_no_miss", 32'(miss), 32'h0);
    chk("simul_score", 32'(score), 32'h4);
    chk("sat_score2", 32'(score2), 32'h3);
    step();

    // Whack edge together with tick in GAP: mole rises, no hit
    whack = 4'hF;
    tick  = 1'b1;
    step();
    tick  = 1'b0;
    m = mole;
    chk("gap_whack_rise", 32'($countones(m)), 32'd1);
    chk("gap_whack_no_hit", 32'(hit), 32'h0);
    step();
    chk("gap_whack_no_hit2", 32'(hit), 32'h0);
    whack = 4'h0;
    step();

    // Drop play mid-UP, then restart
    play = 1'b0;
    step();
    chk("drop_mole", 32'(mole), 32'h0);
    chk("drop_score_held", 32'(score), 32'h4);
    chk("drop_hit_miss", 32'({hit, miss}), 32'h0);
    pulse_tick();
    step();
    chk("drop_tick_ignored", 32'(mole), 32'h0);
    play = 1'b1;
    step();
    chk("restart_score", 32'(score), 32'h0);
    step();

    // 200 moles: one-hot, never the same hole twice in a row, all holes used
    prev_m     = m;
    seen       = 4'h0;
    bad_onehot = 0;
    repeats    = 0;
    for (int i = 0; i < 200; i++) begin
      repeat (i % 5) step();
      pulse_tick();
      m = mole;
      if ($countones(m) != 1) bad_onehot++;
      if (m == prev_m) repeats++;
      seen  |= m;
      prev_m = m;
      whack  = m;
      step();
      whack  = 4'h0;
      step();
    end
    chk("run_onehot", 32'(bad_onehot), 32'd0);
    chk("run_no_repeat", 32'(repeats), 32'd0);
    chk("run_all_holes", 32'(seen), 32'hF);
    chk("run_score", 32'(score), 32'd200);
    chk("run_score2_sat", 32'(score2), 32'h3);

    // Reset mid-operation
    pulse_tick();
    resetn = 1'b0;
    #2;
    chk("async_rst_mole", 32'(mole), 32'h0);
    chk("async_rst_score", 32'(score), 32'h0);
    resetn = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
Name: mole_controller

Overview:
- Consumer of the mole time base: takes the one-cycle `tick` pulse asserted by the top level when the mole time counter reaches 0 (every 25,000,000 clocks at 50 MHz).
- Raises one mole at a time on a pseudo-random hole, keeps it up for a fixed number of ticks, and judges player whacks as hit or miss.
- Maintains the score and drives the mole LEDs.
- Sits between the time counter and the button/LED/score-display logic.

Parameters:
- NUM_HOLES, 4: number of holes; must be a power of two, one of 2, 4 or 8.
- UP_TICKS, 3: number of ticks a mole stays up; legal range 1 to 15.
- SCORE_W, 8: score width.

Ports:
- clock  input  1  system clock, 50 MHz.
- resetn  input  1  asynchronous active-low reset.
- play  input  1  game enable, level.
- tick  input  1  one-cycle pulse from the mole time base.
- whack  input  NUM_HOLES  button levels, already synchronised, active-high.
- mole  output  NUM_HOLES  one-hot raised mole, or all zero.
- score  output  SCORE_W  hit count, saturating.
- hit  output  1  one-cycle pulse on a correct whack.
- miss  output  1  one-cycle pulse when a mole times out.

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low, with ports named `clock` and `resetn`. All outputs are registered.
- Reset values:
  - state = IDLE, mole = 0, score = 0, hit = 0, miss = 0.
  - up_cnt = 0, prev_hole = 0, whack_prev = 0.
  - LFSR = 8'hA5.
- Whack edge detect: `whack_prev` registers `whack` every cycle. A rising edge is `whack & ~whack_prev`. Only rising edges count; a button already held high when a mole rises never scores.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle while `play` = 1 and holds otherwise.
  - Never all-zero.
  - Candidate hole = `lfsr[log2(NUM_HOLES)-1:0]`. If the candidate equals `prev_hole`, use candidate+1 modulo NUM_HOLES, so the same hole is never used twice in a row.
- State machine (states IDLE, GAP, UP):
  - IDLE:
    - mole = 0.
    - When `play` = 1, go to GAP next cycle and clear `score` to 0 in the same cycle.
  - GAP:
    - mole = 0.
    - On `tick`, latch the hole into `prev_hole`, set `mole` one-hot, set `up_cnt` = UP_TICKS-1, and go to UP.
    - `mole` is visible the cycle after `tick`.
  - UP:
    - Rising edge on the raised hole: `hit` = 1 for one cycle; `score` +1, saturating at all-ones; `mole` = 0; go to GAP. All of this appears the cycle after the edge is sampled.
    - Rising edge on any other hole: ignored, with no penalty.
    - On `tick` with `up_cnt` = 0: `miss` = 1 for one cycle; `mole` = 0; go to GAP.
    - On `tick` with `up_cnt` > 0: `up_cnt` -1 and stay in UP.
- Simultaneous events:
  - A correct whack edge and an expiring `tick` in the same cycle count as a hit; no miss is raised.
  - A whack edge and `tick` in GAP: the whack is ignored and the mole rises.
- `play` deasserted: from any state, go to IDLE next cycle; `mole` = 0, `hit` = 0, `miss` = 0, `score` holds its value.
- Reset mid-operation: immediate return to reset values, regardless of state.
- `tick` while in IDLE: ignored.

Decomposition:
- Package `mole_pkg` holds:
  - the state enum: IDLE, GAP, UP;
  - the LFSR seed 8'hA5 and the tap mask;
  - the default tick period constant 25'd24999999, shared with the time base.
- One sub-module, `mole_lfsr`: the 8-bit LFSR with `clock`, `resetn`, `en`, and an 8-bit `q` output.

Test Plan:
- Reset check: hold resetn=0, then release with play=0 -> mole=0, score=0, hit=0, miss=0; mole stays 0 for 100 cycles with ticks present.
- Hit path: play=1, tick pulse, read the raised hole, pulse whack on that hole 5 cycles later -> hit=1 for exactly one cycle, score=1, mole=0 on the same cycle as hit.
- Miss path: with UP_TICKS=3, raise a mole and send 3 further ticks with no whack -> miss=1 on the cycle after the 3rd tick, score unchanged, mole=0.
- Wrong hole and held button:
  - Whack a non-raised hole -> no hit and mole stays up.
  - Hold the correct button high from before the mole rises -> no hit.
  - Release and press again -> hit.
- Simultaneous events: whack edge on the raised hole in the same cycle as the expiring tick -> hit=1, miss=0, score+1.
- Play drop and restart:
  - Drop play mid-UP -> IDLE next cycle, mole=0, score held.
  - Reassert play -> score=0.
  - Over 200 moles, no hole repeats back-to-back.
  - With SCORE_W=2, score saturates at 3.
